// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: reference clock rate and FSM state encoding.
// Optional input synchroniser is selected with the FREQ_METER_SYNC_EN macro (see freq_meter_edge_sync).
package freq_meter_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Rising-edge detector for the measured signal, with an optional 2-FF synchroniser
// in front of it when FREQ_METER_SYNC_EN is defined (for inputs asynchronous to clk).
module freq_meter_edge_sync
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_pulse
);

    logic s;
    logic prev_q;
    logic prev_d;

`ifdef FREQ_METER_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = sig_in;
`endif

    // prev tracks s in every state, so a level already high on entry is not an edge
    always_comb begin
        prev_d     = s;
        edge_pulse = s & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES-long gate window and publishes the count.
// Define FREQ_METER_SYNC_EN to insert a 2-FF synchroniser ahead of edge detection.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned GATE_WIDTH  = 27,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   overflow
);

    localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [GATE_WIDTH-1:0]  gate_ctr_q, gate_ctr_d;
    logic [COUNT_WIDTH-1:0] edge_ctr_q, edge_ctr_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] freq_out_q, freq_out_d;
    logic                   overflow_q, overflow_d;
    logic                   freq_valid_q, freq_valid_d;

    logic                   edge_pulse;
    logic [COUNT_WIDTH-1:0] sum;
    logic                   sum_ovf;

    freq_meter_edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .edge_pulse (edge_pulse)
    );

    // Saturating count including this cycle's edge; reaching or pushing past max flags overflow
    always_comb begin
        sum     = edge_ctr_q;
        sum_ovf = ovf_q;
        if (edge_pulse) begin
            if (edge_ctr_q == COUNT_MAX) begin
                sum_ovf = 1'b1;
            end else begin
                sum = edge_ctr_q + 1'b1;
                if (sum == COUNT_MAX) begin
                    sum_ovf = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_ctr_d   = gate_ctr_q;
        edge_ctr_d   = edge_ctr_q;
        ovf_d        = ovf_q;
        freq_out_d   = freq_out_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_ctr_d = '0;
                edge_ctr_d = '0;
                ovf_d      = 1'b0;
                if (enable) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (gate_ctr_q == GATE_LAST) begin
                    // Terminal cycle publishes even when enable drops on it
                    freq_out_d   = sum;
                    overflow_d   = sum_ovf;
                    freq_valid_d = 1'b1;
                    gate_ctr_d   = '0;
                    edge_ctr_d   = '0;
                    ovf_d        = 1'b0;
                    state_d      = enable ? ST_MEASURE : ST_IDLE;
                end else if (!enable) begin
                    gate_ctr_d = '0;
                    edge_ctr_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    gate_ctr_d = gate_ctr_q + 1'b1;
                    edge_ctr_d = sum;
                    ovf_d      = sum_ovf;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gate_ctr_q   <= '0;
            edge_ctr_q   <= '0;
            ovf_q        <= 1'b0;
            freq_out_q   <= '0;
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_ctr_q   <= gate_ctr_d;
            edge_ctr_q   <= edge_ctr_d;
            ovf_q        <= ovf_d;
            freq_out_q   <= freq_out_d;
            overflow_q   <= overflow_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    assign freq_out   = freq_out_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with a 1000-cycle gate; runs two instances (24-bit and 4-bit counts)
// on the same stimulus. Works with or without FREQ_METER_SYNC_EN.
module tb_freq_meter;

    localparam int GATE = 1000;
`ifdef FREQ_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int MAX_A = 16777215;
    localparam int MAX_B = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        enable;
    logic [23:0] fa;
    logic        va, oa;
    logic [3:0]  fb;
    logic        vb, ob;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(1000), .GATE_WIDTH(10), .COUNT_WIDTH(24)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .freq_out(fa), .freq_valid(va), .overflow(oa)
    );

    freq_meter #(.GATE_CYCLES(1000), .GATE_WIDTH(10), .COUNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .freq_out(fb), .freq_valid(vb), .overflow(ob)
    );

    int checks = 0;
    int errors = 0;
    int period = 0;
    int ph = 0;
    int cur = 0;
    int valid_cnt = 0;

    // Window-level model: edges seen by the (optionally delayed) signal, published per window
    bit m_meas, m_prev, m_s1, m_s2;
    int m_cnt, m_edges;
    int exp_fa, exp_fb;
    bit exp_oa, exp_ob, exp_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_meas = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
            m_cnt = 0; m_edges = 0;
            exp_fa = 0; exp_fb = 0; exp_oa = 0; exp_ob = 0; exp_v = 0;
        end else begin
            bit s;
            s = (LAT == 2) ? m_s2 : sig_in;
            exp_v = 0;
            if (!m_meas) begin
                m_cnt = 0; m_edges = 0; m_meas = enable;
            end else begin
                if (s && !m_prev) m_edges++;
                m_cnt++;
                if (m_cnt == GATE) begin
                    exp_v  = 1;
                    exp_fa = (m_edges >= MAX_A) ? MAX_A : m_edges;
                    exp_oa = (m_edges >= MAX_A);
                    exp_fb = (m_edges >= MAX_B) ? MAX_B : m_edges;
                    exp_ob = (m_edges >= MAX_B);
                    m_cnt = 0; m_edges = 0; m_meas = enable;
                end else if (!enable) begin
                    m_cnt = 0; m_edges = 0; m_meas = 0;
                end
            end
            m_prev = s;
            m_s2 = m_s1;
            m_s1 = sig_in;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("valid_a", va, exp_v);
        chk("freq_a", fa, exp_fa);
        chk("ovf_a", oa, exp_oa);
        chk("valid_b", vb, exp_v);
        chk("freq_b", fb, exp_fb);
        chk("ovf_b", ob, exp_ob);
        if (va) valid_cnt++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_cycle();
            if (period != 0) begin
                ph++;
                if (ph >= period / 2) begin
                    sig_in = ~sig_in;
                    ph = 0;
                end
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!va && n < 3000);
        if (!va) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no freq_valid within %0d cycles", n);
        end
    endtask

    task automatic goto_k(input int k);
        while (cur < k) begin
            tick(1);
            cur++;
        end
    endtask

    initial begin
        int n;
        int w1, w2, w3;
        rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
        tick(3);
        chk("rst_freq", fa, 0);
        chk("rst_valid", va, 0);
        chk("rst_ovf", oa, 0);
        rst = 1'b0;

        // 1: continuous measurement at period 10
        period = 10; ph = 0;
        tick(20);
        enable = 1'b1;
        wait_valid(n);
        chk("t1_first_latency", n, 1001);
        chk("t1_freq", fa, 100);
        chk("t1_ovf", oa, 0);
        wait_valid(n);
        chk("t1_pulse_spacing", n, 1000);
        chk("t1_freq2", fa, 100);

        // 2: reset mid-window
        tick(500);
        rst = 1'b1;
        #1;
        chk("t2_rst_freq", fa, 0);
        chk("t2_rst_valid", va, 0);
        tick(5);
        rst = 1'b0;
        wait_valid(n);
        chk("t2_latency_after_rst", n, 1001);
        wait_valid(n);
        chk("t2_freq", fa, 100);

        // 3: abort and resume
        tick(400);
        enable = 1'b0;
        n = valid_cnt;
        tick(1500);
        chk("t3_no_pulse", valid_cnt - n, 0);
        chk("t3_hold", fa, 100);
        enable = 1'b1;
        wait_valid(n);
        chk("t3_resume_latency", n, 1001);
        chk("t3_freq", fa, 100);

        // 4: saturation of the 4-bit instance, then recovery
        period = 2; ph = 0;
        wait_valid(n);
        wait_valid(n);
        chk("t4_freq_a", fa, 500);
        chk("t4_ovf_a", oa, 0);
        chk("t4_freq_b", fb, 15);
        chk("t4_ovf_b", ob, 1);
        period = 200; ph = 0;
        wait_valid(n);
        wait_valid(n);
        chk("t4_slow_freq_a", fa, 5);
        chk("t4_slow_freq_b", fb, 5);
        chk("t4_slow_ovf_b", ob, 0);

        // 5: constant input levels
        enable = 1'b0; period = 0; sig_in = 1'b1;
        tick(10);
        enable = 1'b1;
        wait_valid(n);
        chk("t5_high_freq", fa, 0);
        wait_valid(n);
        chk("t5_high_freq2", fa, 0);
        sig_in = 1'b0;
        wait_valid(n);
        wait_valid(n);
        chk("t5_low_freq", fa, 0);
        chk("t5_low_ovf_b", ob, 0);

        // 6: edges on the terminal cycle and on the first cycle of the next window
        wait_valid(n);
        cur = 0;
        goto_k(999 - LAT); sig_in = 1'b1;
        goto_k(1000);
        chk("t6_w1_valid", va, 1);
        w1 = int'(fa);
        sig_in = 1'b0;
        goto_k(1100); sig_in = 1'b1;
        goto_k(1110); sig_in = 1'b0;
        goto_k(1200); sig_in = 1'b1;
        goto_k(1210); sig_in = 1'b0;
        goto_k(1300); sig_in = 1'b1;
        goto_k(1310); sig_in = 1'b0;
        goto_k(2000 - LAT); sig_in = 1'b1;
        goto_k(2000);
        chk("t6_w2_valid", va, 1);
        w2 = int'(fa);
        goto_k(2100); sig_in = 1'b0;
        goto_k(3000);
        chk("t6_w3_valid", va, 1);
        w3 = int'(fa);
        chk("t6_terminal_edge", w1, 1);
        chk("t6_mid_edges", w2, 3);
        chk("t6_first_cycle_edge", w3, 1);
        chk("t6_sum", w1 + w2 + w3, 5);

        enable = 1'b0;
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
